uart_rx_8n1: RTL and testbench

Oversampling UART receiver for 8N1 frames (1 start bit, 8 data bits LSB-first, no parity, 1 stop bit). It pairs with the existing `uart_tx_8n1` transmitter on the same link. The receiver recovers bytes from the asynchronous `uart_rx` line, presents each byte with a one-cycle `valid` strobe, and flags frames whose stop bit is bad. It sits between the board RX pin and the byte-level consumer logic.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_8n1.sv | 149 ++++++++++++++
 tb/tb_uart_rx_8n1.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receive FSM state encoding
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - oversampling 8N1 UART receiver with stop-bit error and break handling
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    uart_sync2 #(
        .RESET_VAL(LINE_IDLE)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (uart_rx),
        .q    (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_s != LINE_IDLE) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end
                ST_START: begin
                    // Half a bit in: a still-low line is a real start, and we are now mid-bit.
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (rx_s == LINE_IDLE) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            idx_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s == LINE_IDLE) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Hold here until the line recovers so a stuck-low line yields one error only.
                    if (rx_s == LINE_IDLE) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - directed self-checking bench for uart_rx_8n1
module tb_uart_rx_8n1;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       uart_rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int tests;
    int failed;

    int cyc;
    int valid_cnt;
    int ferr_cnt;
    int both_cnt;
    int busy_cnt;
    int valid_cyc_q[$];
    logic [7:0] valid_dat_q[$];

    int last_start;

    uart_rx_8n1 #(
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .uart_rx  (uart_rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        valid_cnt = 0;
        ferr_cnt  = 0;
        both_cnt  = 0;
        busy_cnt  = 0;
    end

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc_q.push_back(cyc);
            valid_dat_q.push_back(data);
        end
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (valid === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp)
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b);
        last_start = cyc + 1;
        uart_rx = 1'b0;
        cycles(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cycles(16);
        end
        uart_rx = 1'b1;
        cycles(16);
    endtask

    // Start bit plus data bits 0..3 of an all-ones byte, then half of bit 4.
    task automatic send_partial_ff();
        uart_rx = 1'b0;
        cycles(16);
        uart_rx = 1'b1;
        cycles(64 + 8);
    endtask

    int vb;
    int fb;
    int bb;
    int s0;
    int lat;

    initial begin
        tests   = 0;
        failed  = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        uart_rx = 1'b1;
        last_start = 0;
        #1;

        // Reset held for 5 cycles with an idle line
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            check("rst_valid", {31'd0, valid}, 32'd0);
            check("rst_ferr", {31'd0, frame_err}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        check("rst_data", {24'd0, data}, 32'h00);
        rst_n = 1'b1;
        cycles(5);

        // Single frame 0x55
        vb = valid_cnt;
        fb = ferr_cnt;
        send_frame(8'h55);
        cycles(20);
        check("f55_count", valid_cnt - vb, 1);
        check("f55_ferr", ferr_cnt - fb, 0);
        check("f55_data", {24'd0, data}, 32'h55);
        lat = (valid_cnt > vb) ? (valid_cyc_q[vb] - last_start) : -1;
        check("f55_latency_ok", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
        check("f55_busy_after", {31'd0, busy}, 32'd0);

        // Back-to-back 0xA5 then 0x3C without idle gap
        vb = valid_cnt;
        fb = ferr_cnt;
        send_frame(8'hA5);
        send_frame(8'h3C);
        cycles(20);
        check("b2b_count", valid_cnt - vb, 2);
        check("b2b_ferr", ferr_cnt - fb, 0);
        if (valid_cnt - vb >= 2) begin
            check("b2b_data0", {24'd0, valid_dat_q[vb]}, 32'hA5);
            check("b2b_data1", {24'd0, valid_dat_q[vb+1]}, 32'h3C);
            check("b2b_gap", valid_cyc_q[vb+1] - valid_cyc_q[vb], 160);
        end
        check("b2b_data_hold", {24'd0, data}, 32'h3C);

        // Glitch: line low for only 4 cycles
        vb = valid_cnt;
        fb = ferr_cnt;
        bb = busy_cnt;
        uart_rx = 1'b0;
        cycles(4);
        uart_rx = 1'b1;
        cycles(30);
        check("glitch_busy_seen", {31'd0, (busy_cnt - bb > 0)}, 32'd1);
        check("glitch_busy_short", {31'd0, (busy_cnt - bb < 16)}, 32'd1);
        check("glitch_busy_now", {31'd0, busy}, 32'd0);
        check("glitch_valid", valid_cnt - vb, 0);
        check("glitch_ferr", ferr_cnt - fb, 0);

        // Break: line low for 20 bit times, then a good 0x81 frame
        vb = valid_cnt;
        fb = ferr_cnt;
        uart_rx = 1'b0;
        cycles(320);
        check("brk_ferr", ferr_cnt - fb, 1);
        check("brk_valid", valid_cnt - vb, 0);
        check("brk_data_hold", {24'd0, data}, 32'h3C);
        check("brk_busy_held", {31'd0, busy}, 32'd1);
        uart_rx = 1'b1;
        cycles(10);
        check("brk_busy_release", {31'd0, busy}, 32'd0);
        cycles(6);
        vb = valid_cnt;
        send_frame(8'h81);
        cycles(20);
        check("brk_next_count", valid_cnt - vb, 1);
        check("brk_next_data", {24'd0, data}, 32'h81);
        check("brk_ferr_total", ferr_cnt - fb, 1);

        // Abort by dropping en during data bit 4 of 0xFF
        vb = valid_cnt;
        fb = ferr_cnt;
        send_partial_ff();
        check("en_abort_busy_before", {31'd0, busy}, 32'd1);
        en = 1'b0;
        cycles(1);
        check("en_abort_busy_after", {31'd0, busy}, 32'd0);
        cycles(8 + 48 + 16);
        en = 1'b1;
        cycles(20);
        check("en_abort_valid", valid_cnt - vb, 0);
        check("en_abort_ferr", ferr_cnt - fb, 0);
        check("en_abort_data", {24'd0, data}, 32'h81);
        vb = valid_cnt;
        send_frame(8'h12);
        cycles(20);
        check("en_next_count", valid_cnt - vb, 1);
        check("en_next_data", {24'd0, data}, 32'h12);

        // Abort by synchronous reset during data bit 4 of 0xFF
        vb = valid_cnt;
        fb = ferr_cnt;
        send_partial_ff();
        check("rst_abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        cycles(1);
        check("rst_abort_busy_after", {31'd0, busy}, 32'd0);
        check("rst_abort_data", {24'd0, data}, 32'h00);
        rst_n = 1'b1;
        cycles(8 + 48 + 16);
        cycles(20);
        check("rst_abort_valid", valid_cnt - vb, 0);
        check("rst_abort_ferr", ferr_cnt - fb, 0);
        vb = valid_cnt;
        s0 = 0;
        send_frame(8'h6E);
        cycles(20);
        check("rst_next_count", valid_cnt - vb, 1);
        check("rst_next_data", {24'd0, data}, 32'h6E);

        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
